// File: rtl/uart_tx_buffered.sv
// FIFO-buffered 8N1 UART transmitter: bytes written into the FIFO are serialised
// LSB first, back-to-back with no idle gap between queued frames.
module uart_tx_buffered #(
  parameter int unsigned CLOCK_FREQUENCY = 100000000,
  parameter int unsigned BAUD_RATE       = 115200,
  parameter int unsigned FIFO_DEPTH      = 16
) (
  input  logic                                i_Clock,
  input  logic                                i_Reset_n,
  input  logic                                i_Write,
  input  logic [7:0]                          i_Data,
  output logic                                o_Full,
  output logic                                o_Empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     o_Count,
  output logic                                o_Overflow,
  input  logic                                i_Clear_Overflow,
  output logic                                o_TX,
  output logic                                o_Busy_TX
);

  localparam int unsigned DIVIDER = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int unsigned BW      = $clog2(DIVIDER);
  localparam int unsigned PW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(DIVIDER - 1);
  localparam logic [CW-1:0] DEPTH_C     = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_next;
  logic [BW-1:0] baud, baud_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shift, shift_next;
  logic          tx_next;
  logic          pop;
  logic          wr_ok;
  logic          busy_next;
  logic [CW-1:0] count_next;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  // A write while full is dropped even if the engine pops in the same cycle.
  assign wr_ok = i_Write & ~o_Full;

  always_ff @(posedge i_Clock) begin
    if (wr_ok) mem[wr_ptr] <= i_Data;
  end

  always_comb begin
    count_next = o_Count;
    case ({wr_ok, pop})
      2'b10:   count_next = o_Count + 1'b1;
      2'b01:   count_next = o_Count - 1'b1;
      default: count_next = o_Count;
    endcase
  end

  always_comb begin
    state_next = state;
    baud_next  = baud;
    bit_next   = bit_idx;
    shift_next = shift;
    tx_next    = o_TX;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (!o_Empty) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          tx_next    = 1'b0;
          bit_next   = '0;
          baud_next  = BAUD_RELOAD;
          state_next = START;
        end
      end
      START: begin
        if (baud == '0) begin
          tx_next    = shift[0];
          shift_next = {1'b0, shift[7:1]};
          bit_next   = '0;
          baud_next  = BAUD_RELOAD;
          state_next = DATA;
        end else begin
          baud_next = baud - 1'b1;
        end
      end
      DATA: begin
        if (baud == '0) begin
          baud_next = BAUD_RELOAD;
          if (bit_idx == 3'd7) begin
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            tx_next    = shift[0];
            shift_next = {1'b0, shift[7:1]};
            bit_next   = bit_idx + 1'b1;
          end
        end else begin
          baud_next = baud - 1'b1;
        end
      end
      STOP: begin
        if (baud == '0) begin
          // Popping straight into the next start bit keeps queued frames contiguous.
          if (!o_Empty) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr];
            tx_next    = 1'b0;
            bit_next   = '0;
            baud_next  = BAUD_RELOAD;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy_next = (state_next != IDLE) || (count_next != '0);

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) state <= IDLE;
    else            state <= state_next;
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      baud       <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      o_TX       <= 1'b1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_Count    <= '0;
      o_Full     <= 1'b0;
      o_Empty    <= 1'b1;
      o_Overflow <= 1'b0;
      o_Busy_TX  <= 1'b0;
    end else begin
      baud      <= baud_next;
      bit_idx   <= bit_next;
      shift     <= shift_next;
      o_TX      <= tx_next;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      o_Count   <= count_next;
      o_Full    <= (count_next == DEPTH_C);
      o_Empty   <= (count_next == '0);
      o_Busy_TX <= busy_next;
      if (i_Write && o_Full)  o_Overflow <= 1'b1;
      else if (i_Clear_Overflow) o_Overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered with DIVIDER=10 and a 4-deep FIFO: a line monitor
// decodes frames against a scoreboard queue while directed sequences check timing.
module tb_uart_tx_buffered;
  localparam int DIV   = 10;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       full, empty, ovf, tx, busy;
  logic [2:0] count;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  uart_tx_buffered #(
    .CLOCK_FREQUENCY(100),
    .BAUD_RATE(10),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_Clock(clk),
    .i_Reset_n(rst_n),
    .i_Write(wr),
    .i_Data(din),
    .o_Full(full),
    .o_Empty(empty),
    .o_Count(count),
    .o_Overflow(ovf),
    .i_Clear_Overflow(clr),
    .o_TX(tx),
    .o_Busy_TX(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d, input bit accept);
    wr  = 1'b1;
    din = d;
    if (accept) sb.push_back(d);
    tick();
    wr = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((busy || sb.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    check({name, "_drain_timeout"}, n < 3000, 1);
    repeat (5) tick();
    check({name, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic mon_wait(input int n, inout bit aborted);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (!rst_n) aborted = 1'b1;
    end
  endtask

  // Line monitor: samples each bit mid-period, compares against the scoreboard.
  initial begin
    bit         aborted;
    logic [7:0] got;
    logic [7:0] exp_b;
    logic       start_mid, stop_b;
    forever begin
      @(negedge clk);
      if (rst_n && tx == 1'b0) begin
        aborted = 1'b0;
        got     = 8'h00;
        mon_wait(DIV / 2, aborted);
        start_mid = tx;
        for (int j = 0; j < 8; j++) begin
          mon_wait(DIV, aborted);
          got[j] = tx;
        end
        mon_wait(DIV, aborted);
        stop_b = tx;
        if (!aborted) begin
          check("mon_start_bit", start_mid, 0);
          check("mon_stop_bit", stop_b, 1);
          if (sb.size() == 0) begin
            check("mon_unexpected_frame", got, 32'hFFFF_FFFF);
          end else begin
            exp_b = sb.pop_front();
            check("mon_byte", got, exp_b);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic       w;
    logic [7:0] d;
    logic       c;
    logic       acc;
    logic [2:0] cnt;
    logic       fl;
    logic       em;
    logic       ov;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [7:0] pat;
    logic       e;
    int         lows;

    tbl[0] = '{1'b1, 8'h01, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 8'h02, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 8'h03, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 8'h04, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 8'h05, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 8'h06, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0};

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_full", full, 0);
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_ovf", ovf, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset release
    for (int i = 0; i < 100; i++) begin
      tick();
      check("idle_tx_empty_busy", {tx, empty, busy}, 3'b110);
    end

    // Single frame 0xA5, cycle-exact line check
    pat = 8'hA5;
    write_byte(8'hA5, 1'b1);
    check("single_count", count, 1);
    for (int m = 1; m <= 105; m++) begin
      tick();
      if (m <= 10)      e = 1'b0;
      else if (m <= 90) e = pat[(m - 11) / 10];
      else              e = 1'b1;
      check($sformatf("single_tx_m%0d", m), tx, e);
      if (m == 100) check("single_busy_m100", busy, 1);
      if (m == 101) check("single_busy_m101", busy, 0);
    end
    drain("single");

    // Burst of three contiguous frames
    write_byte(8'h55, 1'b1);
    check("burst_count0", count, 1);
    write_byte(8'h0F, 1'b1);
    check("burst_count1", count, 1);
    write_byte(8'hFF, 1'b1);
    check("burst_count2", count, 2);
    for (int m = 3; m <= 310; m++) begin
      tick();
      case (m)
        100: begin check("burst_cnt_m100", count, 2); check("burst_tx_m100", tx, 1); end
        101: begin check("burst_cnt_m101", count, 1); check("burst_tx_m101", tx, 0); end
        200: begin check("burst_cnt_m200", count, 1); check("burst_tx_m200", tx, 1); end
        201: begin check("burst_cnt_m201", count, 0); check("burst_tx_m201", tx, 0); end
        300: check("burst_busy_m300", busy, 1);
        301: begin check("burst_busy_m301", busy, 0); check("burst_tx_m301", tx, 1); end
        default: ;
      endcase
    end
    drain("burst");

    // Table-driven fill/overflow/clear with a 4-deep FIFO
    for (int i = 0; i < 8; i++) begin
      wr  = tbl[i].w;
      din = tbl[i].d;
      clr = tbl[i].c;
      if (tbl[i].w && tbl[i].acc) sb.push_back(tbl[i].d);
      tick();
      check($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
      check($sformatf("tbl%0d_full", i), full, tbl[i].fl);
      check($sformatf("tbl%0d_empty", i), empty, tbl[i].em);
      check($sformatf("tbl%0d_ovf", i), ovf, tbl[i].ov);
    end
    wr  = 1'b0;
    clr = 1'b0;
    drain("table");

    // Write dropped on the exact cycle of a STOP pop with the FIFO full
    for (int i = 0; i < 5; i++) write_byte(8'h11 + 8'(i), 1'b1);
    check("stoppop_full_before", full, 1);
    repeat (96) tick();
    check("stoppop_count_m100", count, 4);
    wr  = 1'b1;
    din = 8'h99;
    tick();
    wr = 1'b0;
    check("stoppop_count", count, 3);
    check("stoppop_ovf", ovf, 1);
    check("stoppop_full", full, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("stoppop_ovf_cleared", ovf, 0);
    drain("stoppop");

    // Reset mid-DATA of 0x3C with two bytes queued
    write_byte(8'h3C, 1'b0);
    check("rstmid_count0", count, 1);
    write_byte(8'hA1, 1'b0);
    check("rstmid_count1", count, 1);
    write_byte(8'hB2, 1'b0);
    check("rstmid_count2", count, 2);
    repeat (38) tick();
    rst_n = 1'b0;
    #1;
    check("rstmid_tx", tx, 1);
    check("rstmid_count", count, 0);
    check("rstmid_empty", empty, 1);
    check("rstmid_busy", busy, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("rstmid_quiet_after_release", lows, 0);
    write_byte(8'h7E, 1'b1);
    drain("rstmid_new");

    check("final_sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
